// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Fetch stage sitting directly in front of the instruction ROM. Owns the PC,
//   drives the ROM enable/address, captures the combinational ROM word into a
//   small in-order FIFO and presents {pc, inst} to decode over valid/ready.
//   Handles decode backpressure, branch redirects and exception flushes
//   (priority: flush > branch_flag > sequential).
//
// Optional build macro:
//   FETCH_ADEL_EN  - keep redirect target low bits, flag misaligned fetches
//                    through out_adel and stop fetching until the next flush.
//
// Ports:
//   clk            clock
//   rst            asynchronous reset, active low
//   rom_ce         ROM enable
//   rom_addr       word-aligned ROM byte address
//   rom_inst       ROM data, valid in the same cycle
//   branch_flag    redirect request from decode
//   branch_target  redirect target
//   flush          exception/control flush
//   new_pc         flush target
//   out_valid      head entry valid
//   out_pc         PC of head entry (0 when empty)
//   out_inst       instruction of head entry (0 when empty)
//   out_ready      decode accepts head entry
//   out_adel       (FETCH_ADEL_EN only) head entry fetched from misaligned PC
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
`ifdef FETCH_ADEL_EN
    output logic        out_adel,
`endif
    input  logic        out_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             r_ce;
    logic [31:0]      r_pc;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_pc_mem   [FIFO_DEPTH];
    logic [31:0]      r_inst_mem [FIFO_DEPTH];

    logic             w_redirect;
    logic [31:0]      w_target_raw;
    logic [31:0]      w_target;
    logic             w_pop;
    logic             w_room;
    logic             w_push;

    assign w_redirect   = flush | branch_flag;
    assign w_target_raw = flush ? new_pc : branch_target;

`ifdef FETCH_ADEL_EN
    logic r_adel_hold;
    logic r_adel_mem [FIFO_DEPTH];

    // Misaligned target is kept so it can be reported with the entry.
    assign w_target = w_target_raw;
    assign w_push   = r_ce & ~w_redirect & w_room & ~r_adel_hold;
`else
    assign w_target = {w_target_raw[31:2], 2'b00};
    assign w_push   = r_ce & ~w_redirect & w_room;
`endif

    assign w_pop  = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO keeps streaming.
    assign w_room = (r_count < CNT_W'(FIFO_DEPTH)) | w_pop;

    assign rom_ce   = r_ce;
    assign rom_addr = {r_pc[31:2], 2'b00};

    assign out_valid = (r_count != '0);
    assign out_pc    = out_valid ? r_pc_mem[r_rptr]   : 32'h0;
    assign out_inst  = out_valid ? r_inst_mem[r_rptr] : 32'h0;

    // r_ce comes up one edge after reset release so the ROM sees a clean
    // enable before the first address is consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ce    <= 1'b0;
            r_pc    <= RESET_PC;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_ce <= 1'b1;
            if (w_redirect) begin
                // Pending entries are stale; any pop this cycle is dropped too.
                r_pc    <= w_target;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                    r_pc   <= r_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // Storage needs no reset: out_* are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wptr]   <= r_pc;
            r_inst_mem[r_wptr] <= rom_inst;
        end
    end

`ifdef FETCH_ADEL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_adel_hold <= 1'b0;
        end else if (flush) begin
            r_adel_hold <= 1'b0;
        end else if (w_push && (r_pc[1:0] != 2'b00)) begin
            r_adel_hold <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_adel_mem[r_wptr] <= (r_pc[1:0] != 2'b00);
        end
    end

    assign out_adel = out_valid ? r_adel_mem[r_rptr] : 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] XK    = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] new_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
`ifdef FETCH_ADEL_EN
    logic        out_adel;
`endif

    int total = 0;
    int bad   = 0;

    // behavioural model state
    logic        m_ce;
    logic [31:0] m_pc;
    logic [31:0] mq_pc[$];
    logic [31:0] mq_inst[$];

    inst_fetch #(.FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .flush(flush), .new_pc(new_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
`ifdef FETCH_ADEL_EN
        .out_adel(out_adel),
`endif
        .out_ready(out_ready)
    );

    // ROM: word content is its address xor a constant; zero when disabled
    assign rom_inst = rom_ce ? (rom_addr ^ XK) : 32'h0;

    wire [97:0] dut_vec = {rom_ce, rom_addr, out_valid, out_pc, out_inst};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_ce = 1'b0;
        m_pc = RPC;
        mq_pc.delete();
        mq_inst.delete();
    endtask

    // one clock edge in the model, from the rules: flush > branch > sequential
    task automatic model_edge();
        logic old_ce, pop, room;
        if (!rst) begin
            model_reset();
            return;
        end
        old_ce = m_ce;
        m_ce = 1'b1;
        if (flush) begin
            mq_pc.delete(); mq_inst.delete();
            m_pc = new_pc & ~32'h3;
        end else if (branch_flag) begin
            mq_pc.delete(); mq_inst.delete();
            m_pc = branch_target & ~32'h3;
        end else if (old_ce) begin
            pop  = (mq_pc.size() > 0) && out_ready;
            room = (mq_pc.size() < DEPTH) || pop;
            if (pop) begin
                void'(mq_pc.pop_front());
                void'(mq_inst.pop_front());
            end
            if (room) begin
                mq_pc.push_back(m_pc);
                mq_inst.push_back(m_pc ^ XK);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    function automatic logic [97:0] exp_vec();
        logic [31:0] hp, hi;
        hp = 32'h0;
        hi = 32'h0;
        if (mq_pc.size() > 0) begin
            hp = mq_pc[0];
            hi = mq_inst[0];
        end
        return {m_ce, m_pc, (mq_pc.size() > 0), hp, hi};
    endfunction

    // advance one cycle: model follows the edge, returns at the next negedge
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        branch_flag = 1'b0; flush = 1'b0;
        branch_target = 32'h0; new_pc = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b1;
        rst = 1'b0;
        model_reset();
        tick(); tick();
        #1;
        total++;
        if (dut_vec !== {1'b0, RPC, 1'b0, 64'h0}) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", dut_vec, {1'b0, RPC, 1'b0, 64'h0});
        end
        rst = 1'b1;
        #1;
        total++;
        if (rom_ce !== 1'b0) begin
            bad++; $display("FAIL ce_after_release got=%b exp=0", rom_ce);
        end
        tick();
        #1;
        total++;
        if (rom_ce !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL ce_rise got ce=%b v=%b exp ce=1 v=0", rom_ce, out_valid);
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL stream cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL stall cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            tick();
        end
        #1;
        total++;
        if (rom_addr !== 32'h8 || out_pc !== 32'h0) begin
            bad++; $display("FAIL stall_hold got addr=%h pc=%h exp addr=8 pc=0", rom_addr, out_pc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || dut_vec !== exp_vec()) begin
                bad++; $display("FAIL drain cyc=%0d got=%h exp_pc=%h exp=%h", i, dut_vec, 32'(i * 4), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_redirect(input logic use_flush);
        do_reset();
        out_ready = 1'b0;
        tick(); tick(); tick();
        branch_flag = 1'b1; branch_target = 32'h100;
        flush = use_flush; new_pc = 32'h20;
        tick();
        idle_inputs();
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL redir_empty flush=%b got=%b exp=0", use_flush, out_valid);
        end
        tick();
        #1;
        total++;
        if (out_valid !== 1'b1 || out_pc !== (use_flush ? 32'h20 : 32'h100)) begin
            bad++; $display("FAIL redir_target flush=%b got v=%b pc=%h", use_flush, out_valid, out_pc);
        end
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL redir_seq cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        tick();
        #1;
        total++;
        if (out_pc !== 32'hFFFF_FFFC || out_inst !== (32'hFFFF_FFFC ^ XK)) begin
            bad++; $display("FAIL wrap_top got pc=%h inst=%h exp pc=fffffffc", out_pc, out_inst);
        end
        tick();
        #1;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || dut_vec !== exp_vec()) begin
            bad++; $display("FAIL wrap_zero got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        tick(); tick(); tick();
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || rom_ce !== 1'b0 || rom_addr !== RPC) begin
            bad++; $display("FAIL async_reset got v=%b ce=%b addr=%h exp v=0 ce=0", out_valid, rom_ce, rom_addr);
        end
        model_reset();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL restart cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 19));
            out_ready     = ($urandom_range(0, 3) != 0);
            flush         = (r == 0) || (r == 3);
            branch_flag   = (r == 1) || (r == 2) || (r == 3);
            new_pc        = $urandom;
            branch_target = $urandom;
            #1;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        out_ready = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect(1'b0);
        test_redirect(1'b1);
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
